// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues req/ack word reads to instruction memory,
// and holds each returned instruction (tagged with its PC) until decode accepts it.
module fetch_unit #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              discard_q, discard_d;
    logic              req_d;
    logic [ADDR_W-1:0] addr_d;
    logic              valid_d;
    logic [DATA_W-1:0] inst_d;
    logic [ADDR_W-1:0] ipc_d;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            inst_valid <= 1'b0;
            inst_out   <= '0;
            inst_pc    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            imem_req   <= req_d;
            imem_addr  <= addr_d;
            inst_valid <= valid_d;
            inst_out   <= inst_d;
            inst_pc    <= ipc_d;
        end
    end

    // Next-state and next-output logic; redirect overrides every other transition
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        req_d     = imem_req;
        addr_d    = imem_addr;
        valid_d   = inst_valid;
        inst_d    = inst_out;
        ipc_d     = inst_pc;

        if (redirect) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            case (state_q)
                S_HOLD: state_d = S_REQ;
                S_WAIT: begin
                    // A request cannot be withdrawn, so wait out its ack and drop the data
                    if (imem_ack) begin
                        req_d     = 1'b0;
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (fetch_en) begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        req_d = 1'b0;
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end else begin
                            inst_d  = imem_rdata;
                            ipc_d   = imem_addr;
                            valid_d = 1'b1;
                            pc_d    = pc_q + ADDR_W'(1);
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        valid_d = 1'b0;
                        if (fetch_en) begin
                            req_d   = 1'b1;
                            addr_d  = pc_q;
                            state_d = S_WAIT;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small variable-latency memory model answers reads with
// addr | 0xA0000000, and each cycle's outputs are checked against hand-derived values.
module tb_fetch_unit;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam logic [ADDR_W-1:0] RST_PC = 16'h0010;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_en;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 0;
    int mem_cnt = 0;
    int hs_cnt  = 0;
    int hs0     = 0;

    fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_en   (fetch_en),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // Memory model: ack after `lat` non-acked request cycles
    always @(negedge clk) begin
        if (rst || !imem_req) begin
            imem_ack = 1'b0;
            mem_cnt  = 0;
        end else if (mem_cnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hA000_0000 | DATA_W'(imem_addr);
            mem_cnt    = 0;
        end else begin
            imem_ack = 1'b0;
            mem_cnt  = mem_cnt + 1;
        end
    end

    // Accepted instructions (a redirect in the same cycle drops the instruction)
    always @(posedge clk) begin
        if (!rst && inst_valid && inst_ready && !redirect) hs_cnt = hs_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   imem_req,   1'b0);
        check({tag, "_addr"},  imem_addr,  16'h0);
        check({tag, "_valid"}, inst_valid, 1'b0);
        check({tag, "_out"},   inst_out,   32'h0);
        check({tag, "_pc"},    inst_pc,    16'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0; redirect = 1'b0; lat = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        imem_ack = 1'b0; imem_rdata = '0; redirect_pc = '0;
        do_reset();
        check_reset_outputs("reset");

        // Stream: one instruction every 2 cycles
        fetch_en = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stream_req",  imem_req,  1'b1);
            check("stream_addr", imem_addr, 16'h0010 + 16'(i));
            step();
            check("stream_valid", inst_valid, 1'b1);
            check("stream_out",   inst_out,   32'hA000_0010 + 32'(i));
            check("stream_pc",    inst_pc,    16'h0010 + 16'(i));
            check("stream_req0",  imem_req,   1'b0);
        end

        // Backpressure
        do_reset();
        fetch_en = 1'b1;
        step();
        step();
        check("bp_first", inst_out, 32'hA000_0010);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", inst_valid, 1'b1);
            check("bp_out",   inst_out,   32'hA000_0010);
            check("bp_pc",    inst_pc,    16'h0010);
            check("bp_req",   imem_req,   1'b0);
        end
        inst_ready = 1'b1;
        lat = 4;
        step();
        check("bp_next_req",  imem_req,  1'b1);
        check("bp_next_addr", imem_addr, 16'h0011);

        // Variable latency: ack after 4 waiting cycles
        hs0 = hs_cnt;
        for (int i = 0; i < 4; i++) begin
            step();
            check("lat_req",   imem_req,   1'b1);
            check("lat_addr",  imem_addr,  16'h0011);
            check("lat_valid", inst_valid, 1'b0);
        end
        step();
        check("lat_valid1", inst_valid, 1'b1);
        check("lat_out",    inst_out,   32'hA000_0011);
        check("lat_pc",     inst_pc,    16'h0011);
        lat = 3;

        // Redirect during wait on 0x0012
        step();
        check("rdw_addr", imem_addr, 16'h0012);
        check("rdw_hs",   hs_cnt,    32'(hs0 + 1));
        redirect = 1'b1; redirect_pc = 16'h0200;
        step();
        redirect = 1'b0;
        check("rdw_req_held", imem_req, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rdw_novalid", inst_valid, 1'b0);
        end
        check("rdw_req0", imem_req, 1'b0);
        lat = 0;
        step();
        check("rdw_req",  imem_req,  1'b1);
        check("rdw_new",  imem_addr, 16'h0200);

        // Redirect together with handshake in hold
        step();
        check("rvh_out", inst_out, 32'hA000_0200);
        check("rvh_pc",  inst_pc,  16'h0200);
        redirect = 1'b1; redirect_pc = 16'h0300;
        step();
        redirect = 1'b0;
        check("rvh_valid", inst_valid, 1'b0);
        check("rvh_req0",  imem_req,   1'b0);
        step();
        check("rvh_req",  imem_req,  1'b1);
        check("rvh_addr", imem_addr, 16'h0300);
        check("rvh_hs",   hs_cnt,    32'(hs0 + 1));

        // Wrap and enable
        step();
        check("wrap_out300", inst_out, 32'hA000_0300);
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        step();
        redirect = 1'b0;
        step();
        check("wrap_addr", imem_addr, 16'hFFFF);
        fetch_en = 1'b0;
        step();
        check("wrap_valid", inst_valid, 1'b1);
        check("wrap_out",   inst_out,   32'hA000_FFFF);
        check("wrap_pc",    inst_pc,    16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            step();
            check("en_noreq", imem_req, 1'b0);
        end
        fetch_en = 1'b1; lat = 4;
        step();
        check("wrap_req",  imem_req,  1'b1);
        check("wrap_zero", imem_addr, 16'h0000);

        // Reset mid-wait
        step();
        rst = 1'b1;
        step();
        check_reset_outputs("rstwait");
        rst = 1'b0; lat = 0;
        step();
        check("post_rst_addr", imem_addr, 16'h0010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the multicycle CPU. It owns the program counter and issues word reads to instruction memory over a req/ack handshake that tolerates variable latency. It holds each returned instruction, tagged with its PC, until the decode stage accepts it over a valid/ready handshake. A redirect input reloads the PC for branches and jumps and squashes any in-flight or held instruction.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- ADDR_W, 16, PC / instruction-memory word-address width
- DATA_W, 32, instruction width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_en  in  1  permits new memory requests; does not abort one in flight
- imem_req  out  1  read request, held high until acked
- imem_addr  out  ADDR_W  word address; stable while imem_req=1
- imem_ack  in  1  read complete; imem_rdata valid in the same cycle
- imem_rdata  in  DATA_W  instruction word
- inst_valid  out  1  inst_out/inst_pc hold a live instruction
- inst_ready  in  1  decode stage accepts the instruction
- inst_out  out  DATA_W  held instruction
- inst_pc  out  ADDR_W  word address of inst_out
- redirect  in  1  load redirect_pc; squash in-flight/held fetch
- redirect_pc  in  ADDR_W  new PC

## Operation
- The PC is word-addressed. It increments by 1 modulo 2^ADDR_W, so 16'hFFFF wraps to 16'h0000.
- States:
  - S_REQ (idle)
  - S_WAIT (request outstanding)
  - S_HOLD (instruction presented)
- All outputs are registered.
- Reset values:
  - pc_q = RESET_PC, state = S_REQ, discard = 0
  - imem_req = 0, imem_addr = 0
  - inst_valid = 0, inst_out = 0, inst_pc = 0
- S_REQ with fetch_en=1 and redirect=0: set imem_req=1 and imem_addr=pc_q, then go to S_WAIT.
- S_WAIT, imem_ack=1 and discard=0:
  - Set imem_req=0, inst_out=imem_rdata, inst_pc=imem_addr, inst_valid=1.
  - Set pc_q=pc_q+1 and go to S_HOLD.
- S_WAIT, imem_ack=1 and discard=1: set imem_req=0 and discard=0, then go to S_REQ. No instruction is presented.
- S_WAIT, imem_ack=0: no change. The request and address are held.
- S_HOLD, inst_ready=1 (handshake): set inst_valid=0.
  - If fetch_en=1: set imem_req=1 and imem_addr=pc_q, then go to S_WAIT.
  - Otherwise go to S_REQ.
- S_HOLD, inst_ready=0: inst_valid, inst_out and inst_pc are held.
- Redirect has highest priority over every other transition:
  - pc_q <= redirect_pc and inst_valid <= 0 in all states.
  - S_REQ: stay in S_REQ. A new request may issue on the next cycle.
  - S_HOLD: the held instruction is dropped even if inst_ready=1 in the same cycle. Go to S_REQ.
  - S_WAIT with imem_ack=0: discard <= 1. imem_req stays high until the ack, because the memory protocol forbids withdrawing a request.
  - S_WAIT with imem_ack=1: the data is dropped, imem_req <= 0, go to S_REQ.
  - A repeated redirect while discard=1 updates pc_q again; discard stays 1.
- fetch_en=0 only blocks new requests. An outstanding request completes and its instruction is presented normally.
- rst=1 overrides everything, including a pending ack; the outstanding read is abandoned. Instruction memory must be reset with the same rst.

## Timing
- S_REQ with fetch_en=1 sampled at edge E0: imem_req is high after E0.
- imem_ack sampled at edge E1: inst_valid is high after E1.
- A handshake at edge E2 (with fetch_en=1) re-raises imem_req after E2. There is no idle cycle between a handshake and the next request.
- Best-case throughput, with ack in the first request cycle and ready always high, is one instruction per 2 cycles.
- Redirect sampled at edge E: the first request to redirect_pc is raised after E+1 (from S_REQ or S_HOLD), or after the discarded ack's edge +1 (from S_WAIT).
- inst_pc always equals the address that was issued for inst_out.

## Test plan
- Reset then stream:
  - Stimulus: RESET_PC=0x0010, fetch_en=1, memory acks the cycle after req with rdata=addr|0xA0000000, inst_ready=1.
  - Response: instructions 0xA0000010, 0xA0000011, 0xA0000012 with matching inst_pc, one every 2 cycles.
- Backpressure:
  - Stimulus: inst_ready=0 for 5 cycles after the first valid.
  - Response: inst_valid, inst_out and inst_pc are stable, imem_req=0, and pc_q does not advance. On ready, the next fetch addr is 0x0011.
- Variable latency:
  - Stimulus: ack delayed 4 cycles.
  - Response: imem_req and imem_addr are held constant for all 4 cycles, and exactly one instruction is presented.
- Redirect during wait:
  - Stimulus: redirect=1, redirect_pc=0x0200 while a fetch of 0x0012 is outstanding; ack arrives 3 cycles later.
  - Response: the 0x0012 data is never presented; the next imem_addr is 0x0200.
- Redirect vs handshake:
  - Stimulus: redirect and inst_ready both high in S_HOLD.
  - Response: inst_valid drops, the held instruction counts as dropped, and the next fetch is redirect_pc.
- Wrap and enable:
  - Stimulus: redirect to 0xFFFF, then fetch_en=0 after that request issues.
  - Response: the instruction at 0xFFFF is presented, pc_q=0x0000, and no further imem_req while fetch_en=0. The same bench asserts rst mid-S_WAIT and checks that all outputs return to their reset values.
